// File: rtl/serdes_pkg.sv
// Shared types and sizing for the serial byte collector.
// Frame length depends on the SBC_PARITY_EN macro: 9 bits when it is defined, 8 bits otherwise.
package serdes_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

`ifdef SBC_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_e;

endpackage

// File: rtl/serial_byte_collector_shift_reg8.sv
// 8-bit shift register with selectable direction. It exposes only its next value,
// so the parent can capture a byte on the same edge that shifts in the final bit.
module shift_reg8
  import serdes_pkg::*;
(
  input  logic              clk,
  input  logic              R,
  input  logic              en_i,
  input  logic              lsb_first_i,
  input  logic              din_i,
  output logic [DATA_W-1:0] data_d_o
);

  logic [DATA_W-1:0] data_q;

  // LSB-first shifts right, so the earliest bit ends up in bit 0.
  always_comb begin
    data_d_o = data_q;
    if (en_i) begin
      data_d_o = lsb_first_i ? {din_i, data_q[DATA_W-1:1]}
                             : {data_q[DATA_W-2:0], din_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge R) begin
    if (R) data_q <= '0;
    else   data_q <= data_d_o;
  end

endmodule

// File: rtl/serial_byte_collector.sv
// Collects serial bits into a byte and holds it until downstream accepts it.
// Defining SBC_PARITY_EN adds a trailing even-parity bit and drives par_err.
module serial_byte_collector
  import serdes_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              R,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              po_ready,
  output logic [DATA_W-1:0] PO,
  output logic              po_valid,
  output logic              busy,
  output logic              par_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] po_q, po_d;
  logic [DATA_W-1:0] sr_d;
  logic              accept;
  logic              last_bit;
  logic              shift_en;

  assign accept   = sin_valid && (state_q != HOLD);
  assign last_bit = (cnt_q == CNT_W'(FRAME_LEN - 1));
  // The parity bit is never shifted in; the data register only takes the first byte's worth.
  assign shift_en = accept && (cnt_q < CNT_W'(DATA_W));

  shift_reg8 u_shift_reg8 (
    .clk         (clk),
    .R           (R),
    .en_i        (shift_en),
    .lsb_first_i (LSB_FIRST),
    .din_i       (sin),
    .data_d_o    (sr_d)
  );

`ifdef SBC_PARITY_EN
  logic par_err_q, par_err_d;
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    po_d    = po_q;
`ifdef SBC_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE, SHIFT: begin
        if (accept) begin
          if (last_bit) begin
            state_d = HOLD;
            cnt_d   = '0;
            po_d    = sr_d;
`ifdef SBC_PARITY_EN
            par_err_d = (^sr_d) ^ sin;
`endif
          end else begin
            state_d = SHIFT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (po_ready) begin
          state_d = IDLE;
`ifdef SBC_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      po_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
    end
  end

`ifdef SBC_PARITY_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) par_err_q <= 1'b0;
    else   par_err_q <= par_err_d;
  end
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign PO       = po_q;
  assign po_valid = (state_q == HOLD);
  assign busy     = (state_q == HOLD);

endmodule

// File: doc/serial_byte_collector.md
SERIAL_BYTE_COLLECTOR -- requirements
Module: serial_byte_collector

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = first accepted bit lands in PO[0]; 0 = first accepted bit lands in PO[7].
REQ-002 Ports SHALL be exactly as follows; port names are fixed.
- clk  in  1  single clock; all state changes on rising edge.
- R  in  1  reset, asynchronous, active-high.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled this cycle.
- po_ready  in  1  downstream 8-bit register accepts PO this cycle.
- PO  out  8  assembled byte, feeding the downstream register's parallel input.
- po_valid  out  1  PO holds a complete byte.
- busy  out  1  high when sin_valid will be ignored.
- par_err  out  1  parity error flag for the current PO.

Function
REQ-003 FSM states SHALL be IDLE, SHIFT and HOLD, with a 4-bit bit counter cnt.
REQ-004 In IDLE or SHIFT, each sin_valid=1 cycle SHALL shift sin into the internal shift register, increment cnt, and move IDLE->SHIFT.
- Direction of the shift is set by LSB_FIRST.
- Cycles with sin_valid=0 SHALL hold all state; gaps of any length are legal.
REQ-005 On acceptance of the last frame bit, the next edge SHALL load PO, set po_valid=1, clear cnt and enter HOLD.
- Last frame bit: bit 8, or bit 9 with PARITY_EN.
- Latency: po_valid rises exactly one cycle after the last bit is accepted.
REQ-006 In HOLD, busy SHALL be 1 and sin_valid SHALL be ignored; in IDLE and SHIFT, busy SHALL be 0.
REQ-007 In HOLD, po_valid&&po_ready SHALL complete the handshake: next edge po_valid=0, state IDLE.
- PO SHALL retain its value until the next frame completes.
REQ-008 po_valid SHALL remain 1 indefinitely while po_ready=0; PO SHALL be stable throughout.
REQ-009 sin_valid in the same cycle as a HOLD handshake SHALL be ignored; the first bit of the next frame is accepted no earlier than the cycle after po_valid falls.
REQ-010 po_ready while po_valid=0 SHALL have no effect.
REQ-011 cnt SHALL never exceed the frame length; wrap occurs only via the REQ-005 clear.

Reset
REQ-012 R=1 SHALL immediately force: state IDLE, cnt=0, shift register=0, PO=8'h00, po_valid=0, busy=0, par_err=0.
REQ-013 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending data; operation resumes on the first edge after R falls.

Configuration
REQ-014 Macro SBC_PARITY_EN:
- Defined: frame length SHALL be 9 bits; bit 9 is an even-parity bit.
- Defined: par_err SHALL be (^data)^parity, loaded with po_valid and cleared on handshake.
- Not defined: frame length SHALL be 8 bits and par_err SHALL be tied 0.

Structure
REQ-015 Package serdes_pkg SHALL hold:
- the state enum {IDLE, SHIFT, HOLD};
- DATA_W=8 and CNT_W=4;
- FRAME_LEN, derived from SBC_PARITY_EN.
REQ-016 The shift register SHALL be a sub-module, shift_reg8, with shift-enable and direction inputs and ports clk and R; FSM and counter stay in the top module.

Verification
REQ-017 LSB_FIRST=1, sin_valid continuous, bits 1,0,1,0,0,1,0,1 -> PO=8'hA5, po_valid=1 one cycle after bit 8, busy=1.
REQ-018 Same frame with sin_valid gaps of 3 cycles between bits -> identical PO=8'hA5, and no early po_valid.
REQ-019 po_ready held 0 for 10 cycles in HOLD, then extra sin_valid pulses -> PO stays 8'hA5; po_ready=1 -> po_valid=0 next cycle, then next frame 8'h3C received correctly.
REQ-020 R pulsed after 5 bits, then full frame 8'hFF -> PO=8'hFF with no residue from the aborted bits; during R, all outputs 0.
REQ-021 LSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> PO=8'hA5 (MSB first).
REQ-022 SBC_PARITY_EN: byte 8'hA5 + parity 0 -> par_err=0; byte 8'hA5 + parity 1 -> par_err=1, cleared after handshake.
